decode_multi: RTL and testbench
===============================

# decode_multi

Parametrised N-wide RISC-V decode stage between the fetch buffer and rename. It decodes up to `DECODE_WIDTH` instructions per cycle into `decoded_inst_t` bundles, with per-lane valid masking and illegal-instruction flagging. A two-entry skid buffer makes `decode_rdy` a registered signal, so no combinational path exists from rename back to fetch. It replaces the fixed 2-wide decode.

## Interface
Parameters:
- `DECODE_WIDTH`, default 2: lanes per bundle; legal values 1..8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush; same effect as `rst` on this block.
- `decode_rdy`  out  1  this block can accept a fetch bundle this cycle.
- `inst_val`  in  1  fetch bundle present.
- `inst_mask`  in  `DECODE_WIDTH`  per-lane valid within the bundle; bit 0 is the oldest lane.
- `inst_pc`  in  `DECODE_WIDTH` x `CPU_ADDR_BITS`  per-lane PC.
- `inst`  in  `DECODE_WIDTH` x `CPU_INST_BITS`  per-lane instruction word.
- `rename_rdy`  in  1  rename accepts the output bundle this cycle.
- `decode_val`  out  1  output bundle valid.
- `decode_inst`  out  `DECODE_WIDTH` x `decoded_inst_t`  decoded bundle.

## Operation
- Transfer events:
  - Input fire = `inst_val && decode_rdy`.
  - Output fire = `decode_val && rename_rdy`.
- Per-lane decode is purely combinational on the input; results are written into the main or skid register.
- `is_valid[i]` = `inst_mask[i]` on a fired bundle.
- `is_illegal[i]` = `inst_mask[i]` and the opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ARI_ITYPE, ARI_RTYPE, CSR.
- An illegal lane has all other control fields zero except `pc`.
- Immediate is selected by format:
  - I-type: ARI_ITYPE, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - CSR: zero-extended `inst[19:15]`.
  - All immediates are sign- or zero-extended to `CPU_DATA_BITS`.
- Control fields:
  - `has_rd`: only for LUI/AUIPC/JAL/JALR/LOAD/ITYPE/RTYPE, and only if `rd != 0`.
  - `alu_a_sel = 1` (use PC) for AUIPC, JAL, BRANCH.
  - `alu_b_sel = 0` (use rs2) only for RTYPE.
  - `uop = {funct7[5], funct3}` for RTYPE.
  - For ITYPE, `uop = {funct7[5], funct3}` when funct3 is SRL/SRA; otherwise `{0, funct3}`.
  - LOAD/STORE: `{0, funct3}`.
  - All other opcodes: ADD.
  - `uop_br = funct3` for BRANCH only.
- Buffer state machine (registers `main_q`, `skid_q`):
  - **EMPTY**: `decode_val = 0`, `decode_rdy = 1`. Input fire -> FULL.
  - **FULL**: `main_q` is presented.
    - Input fire with output fire -> FULL; `main_q` is replaced.
    - Input fire without output fire -> SKID; the new bundle goes to `skid_q`.
    - Output fire without input fire -> EMPTY.
  - **SKID**: `decode_rdy = 0`. Output fire -> FULL, with `skid_q` moving into `main_q`.
- `decode_rdy` = (state != SKID), driven directly from the state register.
- Bundle order is preserved. No lane compaction is performed; masked lanes stay in place with `is_valid = 0`.

## Timing
- Latency: an input fire at cycle t presents the bundle on `decode_val`/`decode_inst` at t+1, provided the buffer was EMPTY or draining.
- Throughput: one bundle per cycle while `rename_rdy` stays high.
- Reset or flush at cycle t:
  - State becomes EMPTY at t+1.
  - `decode_val = 0`, `decode_rdy = 1`, and all `decode_inst` fields are zero.
  - A fetch bundle presented in the same cycle is dropped.
  - `rst`/`flush` take priority over all other events.
- Output stability: while `decode_val && !rename_rdy`, `decode_inst` must not change.
- `inst_val` with `inst_mask == 0` is accepted and forwarded as an all-invalid bundle; it is not dropped.

## Configuration
- `DECODE_MULDIV_EN` defined:
  - RTYPE with `funct7 == FNC7_MULDIV` sets `is_muldiv = 1`.
  - `uop = {0, funct3}`.
- Not defined:
  - Such instructions set `is_illegal = 1`.
  - `is_muldiv` is tied to 0.

## Structure
- Add `DECODE_WIDTH_DEFAULT` and the `is_illegal` field of `decoded_inst_t` to `uarch_pkg`.
- The immediate-format enum and opcode/funct constants belong in `riscv_isa_pkg`.
- Sub-module `decode_lane`: combinational single-instruction decoder, instantiated `DECODE_WIDTH` times with a generate loop.
- Skid buffer and state machine live in `decode_multi`.

## Test plan
- **Reset:** with `DECODE_WIDTH=2`, hold `rst` for 1 cycle -> `decode_val = 0`, `decode_rdy = 1`, `decode_inst` all zeros.
- **Basic decode:**
  - Stimulus: `inst = {0x00A00093, 0xFFC10113}` (addi x1,x0,10; addi x2,x2,-4), mask 2'b11, `rename_rdy = 1`.
  - Next cycle: imm 10 and 0xFFFFFFFC; `has_rd = 1` on both lanes.
- **Backpressure:**
  - Stimulus: `rename_rdy = 0`; fire bundles A and B on consecutive cycles.
  - Required: FULL, then SKID, with `decode_rdy = 0`; A held stable.
  - Then raise `rename_rdy`: A, then B, are output in order; `decode_rdy` returns to 1.
- **Illegal and masking:**
  - Stimulus: lane 0 = 0xFFFFFFFF, lane 1 = 0x00000013 with mask 2'b10.
  - Required: lane 0 `is_valid = 0`, `is_illegal = 0`; with mask 2'b11, lane 0 `is_illegal = 1`.
- **Flush in SKID:** assert `flush` with both registers full and `inst_val = 1` -> next cycle EMPTY, `decode_val = 0`, and the input bundle is never output.
- **Macro:**
  - Stimulus: `mul x3,x1,x2` (0x022081B3).
  - With `DECODE_MULDIV_EN`: `is_muldiv = 1`, `is_illegal = 0`.
  - Without it: `is_illegal = 1`.
  - Repeat with `DECODE_WIDTH=4`.

Source files
------------

// File: rtl/decode_multi_pkg.sv
// decode_multi_pkg: shared types, ISA constants and the immediate generator
// for the N-wide decode stage. The optional M-extension decode is enabled by
// defining DECODE_MULDIV_EN; this package is the same in both builds.
package decode_multi_pkg;

  localparam int CPU_ADDR_BITS        = 32;
  localparam int CPU_INST_BITS        = 32;
  localparam int CPU_DATA_BITS        = 32;
  localparam int DECODE_WIDTH_DEFAULT = 2;

  // Major opcodes accepted by this decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  localparam logic [6:0] FNC7_MULDIV  = 7'b0000001;
  localparam logic [2:0] FNC3_SRL_SRA = 3'b101;
  localparam logic [3:0] UOP_ADD      = 4'b0000;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_CSR  = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] pc;
    logic                     is_valid;
    logic                     is_illegal;
    logic                     has_rd;
    logic [4:0]               rd;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [CPU_DATA_BITS-1:0] imm;
    logic                     alu_a_sel;   // 1: operand A is the PC
    logic                     alu_b_sel;   // 0: operand B is rs2, 1: immediate
    logic [3:0]               uop;
    logic [2:0]               uop_br;
    logic                     is_muldiv;
  } decoded_inst_t;

  // Build the extended immediate for the given instruction format
  function automatic logic [CPU_DATA_BITS-1:0] gen_imm(input imm_fmt_e fmt,
                                                       input logic [CPU_INST_BITS-1:0] ins);
    logic [CPU_DATA_BITS-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_CSR: imm = {27'b0, ins[19:15]};
      default: imm = {CPU_DATA_BITS{1'b0}};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_multi_if.sv
// decode_multi_if: fetch-side and rename-side handshake bundle of the decode
// stage. The slave modport is the decode block, the master the environment.
interface decode_multi_if import decode_multi_pkg::*; #(
  parameter int DECODE_WIDTH = DECODE_WIDTH_DEFAULT
);
  logic                                        decode_rdy;
  logic                                        inst_val;
  logic [DECODE_WIDTH-1:0]                     inst_mask;
  logic [DECODE_WIDTH-1:0][CPU_ADDR_BITS-1:0]  inst_pc;
  logic [DECODE_WIDTH-1:0][CPU_INST_BITS-1:0]  inst;
  logic                                        rename_rdy;
  logic                                        decode_val;
  decoded_inst_t [DECODE_WIDTH-1:0]            decode_inst;

  modport slave (
    output decode_rdy, decode_val, decode_inst,
    input  inst_val, inst_mask, inst_pc, inst, rename_rdy
  );

  modport master (
    input  decode_rdy, decode_val, decode_inst,
    output inst_val, inst_mask, inst_pc, inst, rename_rdy
  );
endinterface

// File: rtl/decode_multi_lane.sv
// decode_multi_lane: combinational single-instruction RISC-V decoder.
// Define DECODE_MULDIV_EN to decode RTYPE MUL/DIV; otherwise they are illegal.
module decode_multi_lane import decode_multi_pkg::*; (
  input  logic                     lane_valid,
  input  logic [CPU_ADDR_BITS-1:0] pc,
  input  logic [CPU_INST_BITS-1:0] inst,
  output decoded_inst_t            dec
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  logic       legal;
  logic       writes_rd;
  logic       a_sel;
  logic       b_sel;
  logic [3:0] uop;
  logic [2:0] uop_br;
  logic       muldiv;
  imm_fmt_e   fmt;

  // Opcode classification into control fields and immediate format
  always_comb begin
    legal     = 1'b0;
    writes_rd = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b1;
    uop       = UOP_ADD;
    uop_br    = 3'b000;
    muldiv    = 1'b0;
    fmt       = IMM_NONE;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; writes_rd = 1'b1; fmt = IMM_U;
      end
      OPC_AUIPC: begin
        legal = 1'b1; writes_rd = 1'b1; a_sel = 1'b1; fmt = IMM_U;
      end
      OPC_JAL: begin
        legal = 1'b1; writes_rd = 1'b1; a_sel = 1'b1; fmt = IMM_J;
      end
      OPC_JALR: begin
        legal = 1'b1; writes_rd = 1'b1; fmt = IMM_I;
      end
      OPC_BRANCH: begin
        legal = 1'b1; a_sel = 1'b1; uop_br = funct3; fmt = IMM_B;
      end
      OPC_LOAD: begin
        legal = 1'b1; writes_rd = 1'b1; uop = {1'b0, funct3}; fmt = IMM_I;
      end
      OPC_STORE: begin
        legal = 1'b1; uop = {1'b0, funct3}; fmt = IMM_S;
      end
      OPC_ITYPE: begin
        legal = 1'b1; writes_rd = 1'b1; fmt = IMM_I;
        // Only shifts right carry the arithmetic/logical selector in funct7
        if (funct3 == FNC3_SRL_SRA) begin
          uop = {funct7[5], funct3};
        end else begin
          uop = {1'b0, funct3};
        end
      end
      OPC_RTYPE: begin
        legal = 1'b1; writes_rd = 1'b1; b_sel = 1'b0;
        if (funct7 == FNC7_MULDIV) begin
`ifdef DECODE_MULDIV_EN
          muldiv = 1'b1;
          uop    = {1'b0, funct3};
`else
          legal  = 1'b0;
`endif
        end else begin
          uop = {funct7[5], funct3};
        end
      end
      OPC_CSR: begin
        legal = 1'b1; fmt = IMM_CSR;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Assemble the bundle; masked or illegal lanes keep only pc and flags
  always_comb begin
    dec    = '0;
    dec.pc = pc;
    if (lane_valid && legal) begin
      dec.is_valid  = 1'b1;
      dec.has_rd    = writes_rd && (rd != 5'd0);
      dec.rd        = rd;
      dec.rs1       = rs1;
      dec.rs2       = rs2;
      dec.imm       = gen_imm(fmt, inst);
      dec.alu_a_sel = a_sel;
      dec.alu_b_sel = b_sel;
      dec.uop       = uop;
      dec.uop_br    = uop_br;
      dec.is_muldiv = muldiv;
    end else begin
      dec.is_valid   = lane_valid;
      dec.is_illegal = lane_valid;
    end
  end

endmodule

// File: rtl/decode_multi.sv
// decode_multi: N-wide decode stage with a two-entry skid buffer so that
// decode_rdy is registered. Optional MUL/DIV decode: define DECODE_MULDIV_EN.
module decode_multi import decode_multi_pkg::*; #(
  parameter int DECODE_WIDTH = DECODE_WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  decode_multi_if.slave   bus
);

  decoded_inst_t [DECODE_WIDTH-1:0] lane_dec;
  decoded_inst_t [DECODE_WIDTH-1:0] main_q;
  decoded_inst_t [DECODE_WIDTH-1:0] skid_q;
  buf_state_e                       state_q;
  logic                             val_q;
  logic                             rdy_q;
  logic                             in_fire;
  logic                             out_fire;

  for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
    decode_multi_lane u_lane (
      .lane_valid (bus.inst_mask[i]),
      .pc         (bus.inst_pc[i]),
      .inst       (bus.inst[i]),
      .dec        (lane_dec[i])
    );
  end

  assign in_fire  = bus.inst_val && rdy_q;
  assign out_fire = val_q && bus.rename_rdy;

  assign bus.decode_rdy  = rdy_q;
  assign bus.decode_val  = val_q;
  assign bus.decode_inst = main_q;

  // Skid-buffer state machine; reset/flush drop everything including input
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      val_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q  <= lane_dec;
            state_q <= ST_FULL;
            val_q   <= 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_q <= lane_dec;
          end else if (in_fire) begin
            skid_q  <= lane_dec;
            state_q <= ST_SKID;
            rdy_q   <= 1'b0;
          end else if (out_fire) begin
            state_q <= ST_EMPTY;
            val_q   <= 1'b0;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state_q <= ST_FULL;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          val_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_multi.sv
// tb_decode_multi: randomized self-checking bench for decode_multi with a
// queue-based reference model (occupancy = queue depth) on a 2-wide instance
// and a 4-wide instance for the MUL/DIV decode.
module tb_decode_multi;
  import decode_multi_pkg::*;

  typedef decoded_inst_t [1:0] bundle2_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  decode_multi_if #(.DECODE_WIDTH(2)) bus2 ();
  decode_multi_if #(.DECODE_WIDTH(4)) bus4 ();

  decode_multi #(.DECODE_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .flush(flush), .bus(bus2));
  decode_multi #(.DECODE_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .flush(flush), .bus(bus4));

  int n_checks = 0;
  int n_pass   = 0;
  bundle2_t exp_q[$];

`ifdef DECODE_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // Reference decode of one instruction, straight from the ISA field rules
  function automatic decoded_inst_t model_lane(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic en);
    decoded_inst_t d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    bit known;
    bit md;
    d = '0;
    d.pc = pc;
    if (!en) return d;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    known = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    md = (op == 7'h33) && (f7 == 7'h01);
    d.is_valid = 1'b1;
    if (!known || (md && !MD_EN)) begin
      d.is_illegal = 1'b1;
      return d;
    end
    d.rd  = ins[11:7];
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.has_rd    = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && (ins[11:7] != 5'd0);
    d.alu_a_sel = op inside {7'h17, 7'h6F, 7'h63};
    d.alu_b_sel = (op != 7'h33);
    d.uop_br    = (op == 7'h63) ? f3 : 3'd0;
    d.is_muldiv = md;
    if (op == 7'h33)                     d.uop = md ? {1'b0, f3} : {f7[5], f3};
    else if (op == 7'h13)                d.uop = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
    else if (op == 7'h03 || op == 7'h23) d.uop = {1'b0, f3};
    else                                 d.uop = 4'd0;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    if (op inside {7'h13, 7'h03, 7'h67}) d.imm = i12;
    else if (op == 7'h23)                d.imm = s12;
    else if (op == 7'h63)                d.imm = b13;
    else if (op inside {7'h37, 7'h17})   d.imm = ins[31:12] * 32'd4096;
    else if (op == 7'h6F)                d.imm = j21;
    else if (op == 7'h73)                d.imm = 32'(ins[19:15]);
    else                                 d.imm = 32'd0;
    return d;
  endfunction

  // Drive one cycle on the 2-wide bus and advance the reference queue
  task automatic drive_cycle(input logic v, input logic [1:0] m, input logic [1:0][31:0] pcs,
                             input logic [1:0][31:0] ins, input logic rr, input logic fl);
    bundle2_t b;
    bit in_fire;
    bit out_fire;
    bus2.inst_val   = v;
    bus2.inst_mask  = m;
    bus2.inst_pc    = pcs;
    bus2.inst       = ins;
    bus2.rename_rdy = rr;
    flush           = fl;
    in_fire  = v && (exp_q.size() < 2);
    out_fire = (exp_q.size() > 0) && rr;
    for (int i = 0; i < 2; i++) b[i] = model_lane(ins[i], pcs[i], m[i]);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) exp_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus2.inst_val = 1'b1; bus2.inst_mask = 2'b11; bus2.rename_rdy = 1'b0;
    bus2.inst_pc = {32'h0000_0104, 32'h0000_0100};
    bus2.inst = {32'h00A0_0093, 32'h00A0_0093};
    bus4.inst_val = 1'b1; bus4.inst_mask = 4'hF; bus4.rename_rdy = 1'b0;
    bus4.inst_pc = '0; bus4.inst = {4{32'h00A0_0093}};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus4.inst_val = 1'b0;
    exp_q.delete();
    n_checks++;
    if (bus2.decode_val !== 1'b0) $display("FAIL reset_val: got %b want 0", bus2.decode_val);
    else n_pass++;
    n_checks++;
    if (bus2.decode_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", bus2.decode_rdy);
    else n_pass++;
    n_checks++;
    if (bus2.decode_inst !== '0) $display("FAIL reset_inst: got %h want 0", bus2.decode_inst);
    else n_pass++;
    n_checks++;
    if (bus4.decode_val !== 1'b0 || bus4.decode_inst !== '0)
      $display("FAIL reset_w4: got val %b inst %h want 0", bus4.decode_val, bus4.decode_inst);
    else n_pass++;
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (bus2.decode_val !== 1'b0) $display("FAIL reset_drop: got %b want 0", bus2.decode_val);
    else n_pass++;
  endtask

  task automatic test_basic();
    drive_cycle(1'b1, 2'b11, {32'h0000_1004, 32'h0000_1000}, {32'hFFC1_0113, 32'h00A0_0093}, 1'b1, 1'b0);
    n_checks++;
    if (bus2.decode_val !== 1'b1) $display("FAIL basic_val: got %b want 1", bus2.decode_val);
    else n_pass++;
    n_checks++;
    if (bus2.decode_inst[0].imm !== 32'd10) $display("FAIL basic_imm0: got %h want 0000000a", bus2.decode_inst[0].imm);
    else n_pass++;
    n_checks++;
    if (bus2.decode_inst[1].imm !== 32'hFFFF_FFFC) $display("FAIL basic_imm1: got %h want fffffffc", bus2.decode_inst[1].imm);
    else n_pass++;
    n_checks++;
    if (bus2.decode_inst[0].has_rd !== 1'b1 || bus2.decode_inst[1].has_rd !== 1'b1)
      $display("FAIL basic_has_rd: got %b%b want 11", bus2.decode_inst[1].has_rd, bus2.decode_inst[0].has_rd);
    else n_pass++;
    n_checks++;
    if (bus2.decode_inst !== exp_q[0]) $display("FAIL basic_bundle: got %h want %h", bus2.decode_inst, exp_q[0]);
    else n_pass++;
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (bus2.decode_val !== 1'b0) $display("FAIL basic_drain: got %b want 0", bus2.decode_val);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [1:0][31:0] pa;
    logic [1:0][31:0] ia;
    logic [1:0][31:0] pb;
    logic [1:0][31:0] ib;
    bundle2_t ea;
    bundle2_t eb;
    pa = {32'h0000_2004, 32'h0000_2000}; ia = {32'h0051_0193, 32'h0000_0117};
    pb = {32'h0000_2008, 32'h0000_200C}; ib = {32'hFE20_8EE3, 32'h1234_5237};
    for (int i = 0; i < 2; i++) begin
      ea[i] = model_lane(ia[i], pa[i], 1'b1);
      eb[i] = model_lane(ib[i], pb[i], 1'b1);
    end
    drive_cycle(1'b1, 2'b11, pa, ia, 1'b0, 1'b0);
    n_checks++;
    if (bus2.decode_val !== 1'b1 || bus2.decode_rdy !== 1'b1 || bus2.decode_inst !== ea)
      $display("FAIL bp_full: got val %b rdy %b inst %h want 1 1 %h", bus2.decode_val, bus2.decode_rdy, bus2.decode_inst, ea);
    else n_pass++;
    drive_cycle(1'b1, 2'b11, pb, ib, 1'b0, 1'b0);
    n_checks++;
    if (bus2.decode_rdy !== 1'b0) $display("FAIL bp_skid_rdy: got %b want 0", bus2.decode_rdy);
    else n_pass++;
    drive_cycle(1'b1, 2'b11, pa, ib, 1'b0, 1'b0);
    n_checks++;
    if (bus2.decode_inst !== ea || bus2.decode_val !== 1'b1)
      $display("FAIL bp_hold: got %h want %h", bus2.decode_inst, ea);
    else n_pass++;
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (bus2.decode_inst !== eb || bus2.decode_rdy !== 1'b1 || bus2.decode_val !== 1'b1)
      $display("FAIL bp_second: got rdy %b inst %h want 1 %h", bus2.decode_rdy, bus2.decode_inst, eb);
    else n_pass++;
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (bus2.decode_val !== 1'b0) $display("FAIL bp_empty: got %b want 0", bus2.decode_val);
    else n_pass++;
  endtask

  task automatic test_illegal_mask();
    decoded_inst_t ill;
    drive_cycle(1'b1, 2'b10, {32'h0000_3004, 32'h0000_3000}, {32'h0000_0013, 32'hFFFF_FFFF}, 1'b1, 1'b0);
    n_checks++;
    if (bus2.decode_inst[0].is_valid !== 1'b0 || bus2.decode_inst[0].is_illegal !== 1'b0)
      $display("FAIL mask_lane0: got v%b i%b want v0 i0", bus2.decode_inst[0].is_valid, bus2.decode_inst[0].is_illegal);
    else n_pass++;
    n_checks++;
    if (bus2.decode_inst[1].is_valid !== 1'b1 || bus2.decode_inst[1].has_rd !== 1'b0)
      $display("FAIL mask_lane1: got v%b rd%b want v1 rd0", bus2.decode_inst[1].is_valid, bus2.decode_inst[1].has_rd);
    else n_pass++;
    drive_cycle(1'b1, 2'b11, {32'h0000_3004, 32'h0000_3000}, {32'h0000_0013, 32'hFFFF_FFFF}, 1'b1, 1'b0);
    ill = '0; ill.pc = 32'h0000_3000; ill.is_valid = 1'b1; ill.is_illegal = 1'b1;
    n_checks++;
    if (bus2.decode_inst[0] !== ill) $display("FAIL illegal_lane0: got %h want %h", bus2.decode_inst[0], ill);
    else n_pass++;
    drive_cycle(1'b1, 2'b00, {32'h0000_3014, 32'h0000_3010}, {32'h0000_0013, 32'h0000_0013}, 1'b1, 1'b0);
    n_checks++;
    if (bus2.decode_val !== 1'b1 || bus2.decode_inst[0].is_valid !== 1'b0 || bus2.decode_inst[1].is_valid !== 1'b0)
      $display("FAIL mask_zero: got val %b v%b%b want 1 v00", bus2.decode_val, bus2.decode_inst[1].is_valid, bus2.decode_inst[0].is_valid);
    else n_pass++;
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_skid();
    drive_cycle(1'b1, 2'b11, {32'h0000_4004, 32'h0000_4000}, {32'h0010_0093, 32'h0020_0113}, 1'b0, 1'b0);
    drive_cycle(1'b1, 2'b11, {32'h0000_400C, 32'h0000_4008}, {32'h0030_0193, 32'h0040_0213}, 1'b0, 1'b0);
    n_checks++;
    if (bus2.decode_rdy !== 1'b0) $display("FAIL flush_pre_skid: got %b want 0", bus2.decode_rdy);
    else n_pass++;
    drive_cycle(1'b1, 2'b11, {32'h0000_4014, 32'h0000_4010}, {32'h0050_0293, 32'h0060_0313}, 1'b0, 1'b1);
    n_checks++;
    if (bus2.decode_val !== 1'b0 || bus2.decode_rdy !== 1'b1 || bus2.decode_inst !== '0)
      $display("FAIL flush_state: got val %b rdy %b inst %h want 0 1 0", bus2.decode_val, bus2.decode_rdy, bus2.decode_inst);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if (bus2.decode_val !== 1'b0) $display("FAIL flush_no_output: got %b want 0 (cycle %0d)", bus2.decode_val, k);
      else n_pass++;
    end
  endtask

  task automatic test_muldiv();
    bit ok;
    bus4.inst_val = 1'b1; bus4.inst_mask = 4'hF; bus4.rename_rdy = 1'b1;
    bus4.inst_pc = {32'h0000_500C, 32'h0000_5008, 32'h0000_5004, 32'h0000_5000};
    bus4.inst = {4{32'h0220_81B3}};
    drive_cycle(1'b1, 2'b11, {32'h0000_5004, 32'h0000_5000}, {32'h0220_81B3, 32'h0220_81B3}, 1'b1, 1'b0);
    bus4.inst_val = 1'b0;
    n_checks++;
    if (bus2.decode_inst[0].is_muldiv !== MD_EN || bus2.decode_inst[0].is_illegal !== !MD_EN)
      $display("FAIL muldiv_w2: got md%b il%b want md%b il%b", bus2.decode_inst[0].is_muldiv,
               bus2.decode_inst[0].is_illegal, MD_EN, !MD_EN);
    else n_pass++;
    n_checks++;
    if (bus2.decode_inst !== exp_q[0]) $display("FAIL muldiv_w2_bundle: got %h want %h", bus2.decode_inst, exp_q[0]);
    else n_pass++;
    ok = (bus4.decode_val === 1'b1);
    for (int i = 0; i < 4; i++)
      if (bus4.decode_inst[i] !== model_lane(32'h0220_81B3, 32'h0000_5000 + 32'(4 * i), 1'b1)) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL muldiv_w4: got val %b inst %h", bus4.decode_val, bus4.decode_inst);
    else n_pass++;
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    logic [1:0][31:0] pcs;
    logic [1:0][31:0] ins;
    logic [31:0] r;
    logic v;
    logic rr;
    logic fl;
    int errs;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F, 7'h0B};
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        r = $urandom();
        ins[i] = {r[31:7], ops[$urandom_range(0, 11)]};
        if (ins[i][6:0] == 7'h33 && $urandom_range(0, 3) == 0) ins[i][31:25] = 7'h01;
        pcs[i] = $urandom();
      end
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 40) == 0);
      drive_cycle(v, 2'($urandom_range(0, 3)), pcs, ins, rr, fl);
      n_checks++;
      if (bus2.decode_val !== (exp_q.size() > 0) || bus2.decode_rdy !== (exp_q.size() < 2)) begin
        $display("FAIL rand_hs: cycle %0d got val %b rdy %b want depth %0d", c, bus2.decode_val, bus2.decode_rdy, exp_q.size());
        errs++;
      end else n_pass++;
      if (exp_q.size() > 0) begin
        n_checks++;
        if (bus2.decode_inst !== exp_q[0]) begin
          if (errs < 10) $display("FAIL rand_inst: cycle %0d got %h want %h", c, bus2.decode_inst, exp_q[0]);
          errs++;
        end else n_pass++;
      end
    end
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal_mask();
    test_flush_skid();
    test_muldiv();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
